// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg
//   Shared definitions for the reg_file_sb register file: default
//   data/address/immediate widths and the clear-sweep FSM state type.
//   Optional feature macro (used by reg_file_sb): REG_FILE_SB_BYPASS_EN.
package reg_file_sb_pkg;

  localparam int RF_W_DEF   = 8;
  localparam int RF_A_DEF   = 2;
  localparam int RF_IMM_DEF = 4;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if
//   Bundles the register-file access, scoreboard and clear-control signals.
//   master: drives WriteEn/MovEn/Waddr/DataIn/MovImm, RaddrA/RaddrB,
//           IssueEn/IssueAddr, ClearReq; observes DataOutA/B, PendA/B,
//           ClearBusy.
//   slave : the register file (reverse directions).
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int W   = RF_W_DEF,
  parameter int A   = RF_A_DEF,
  parameter int IMM = RF_IMM_DEF
);

  logic           WriteEn;
  logic           MovEn;
  logic [A-1:0]   Waddr;
  logic [W-1:0]   DataIn;
  logic [IMM-1:0] MovImm;
  logic [A-1:0]   RaddrA;
  logic [A-1:0]   RaddrB;
  logic [W-1:0]   DataOutA;
  logic [W-1:0]   DataOutB;
  logic           IssueEn;
  logic [A-1:0]   IssueAddr;
  logic           PendA;
  logic           PendB;
  logic           ClearReq;
  logic           ClearBusy;

  modport master (
    output WriteEn, MovEn, Waddr, DataIn, MovImm, RaddrA, RaddrB,
           IssueEn, IssueAddr, ClearReq,
    input  DataOutA, DataOutB, PendA, PendB, ClearBusy
  );

  modport slave (
    input  WriteEn, MovEn, Waddr, DataIn, MovImm, RaddrA, RaddrB,
           IssueEn, IssueAddr, ClearReq,
    output DataOutA, DataOutB, PendA, PendB, ClearBusy
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// rf_scoreboard
//   One pending bit per register. Issue sets a bit, a write/move clears it,
//   a clear-sweep start wipes all bits. Issue beats write on the same address.
//   Ports: Clk, Reset (sync, active-low), clr_all, set_en/set_addr,
//          wr_clr_en/wr_addr, raddr_a/raddr_b -> pend_a/pend_b (combinational).
module rf_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int A = RF_A_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr_all,
  input  logic         set_en,
  input  logic [A-1:0] set_addr,
  input  logic         wr_clr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [A-1:0] raddr_a,
  input  logic [A-1:0] raddr_b,
  output logic         pend_a,
  output logic         pend_b
);

  localparam int D = 2 ** A;

  logic [D-1:0] pend_r;
  logic [D-1:0] pend_nxt_s;

  // Next-state of every pending bit: wipe > set > write-clear > hold.
  always_comb begin
    pend_nxt_s = pend_r;
    for (int i = 0; i < D; i++) begin
      if (clr_all) begin
        pend_nxt_s[i] = 1'b0;
      end else if (set_en && (set_addr == A'(i))) begin
        pend_nxt_s[i] = 1'b1;
      end else if (wr_clr_en && (wr_addr == A'(i))) begin
        pend_nxt_s[i] = 1'b0;
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end
    end
  end

  // Pending-bit storage with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pend_r <= {D{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  assign pend_a = pend_r[raddr_a];
  assign pend_b = pend_r[raddr_b];

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   2**A x W register file with two combinational read ports, a full-word
//   write, a low-IMM-bit move-immediate, a per-register pending scoreboard
//   and a one-register-per-cycle clear sweep.
//   Ports: Clk, Reset (synchronous, active-low), bus (reg_file_sb_if.slave).
//   Optional macro REG_FILE_SB_BYPASS_EN: reads of the register being
//   written/moved return the value it will hold after the edge.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int W   = RF_W_DEF,
  parameter int A   = RF_A_DEF,
  parameter int IMM = RF_IMM_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  reg_file_sb_if.slave bus
);

  localparam int D = 2 ** A;

  localparam logic [0:0]   ST_IDLE  = 1'(RF_IDLE);
  localparam logic [0:0]   ST_CLEAR = 1'(RF_CLEAR);
  localparam logic [A-1:0] CNT_ONE  = A'(32'd1);
  localparam logic [A-1:0] CNT_LAST = A'(D - 1);
  localparam logic [W-1:0] W_ZERO   = {W{1'b0}};
  // Ones in the bits a move overwrites; all ones when IMM == W.
  localparam logic [W-1:0] IMM_MASK = {W{1'b1}} >> (W - IMM);

  logic [0:0]   state_r;
  logic [A-1:0] sweep_cnt_r;
  logic [W-1:0] regs_r [D];

  logic         busy_s;
  logic         wr_acc_s;
  logic         mov_acc_s;
  logic         wr_any_s;
  logic         issue_acc_s;
  logic         clr_start_s;
  logic [W-1:0] wr_data_s;
  logic [W-1:0] rd_a_s;
  logic [W-1:0] rd_b_s;

  // Keep the upper bits of the current word, replace the low IMM bits.
  function automatic logic [W-1:0] mov_merge(input logic [W-1:0]   cur,
                                             input logic [IMM-1:0] imm);
    return (cur & ~IMM_MASK) | W'(imm);
  endfunction

  // Command qualification: nothing but the sweep is accepted while busy.
  always_comb begin
    busy_s      = (state_r == ST_CLEAR);
    wr_acc_s    = Reset & ~busy_s & bus.WriteEn;
    mov_acc_s   = Reset & ~busy_s & bus.MovEn & ~bus.WriteEn;
    wr_any_s    = wr_acc_s | mov_acc_s;
    issue_acc_s = Reset & ~busy_s & bus.IssueEn;
    clr_start_s = Reset & ~busy_s & bus.ClearReq;
    if (wr_acc_s) begin
      wr_data_s = bus.DataIn;
    end else begin
      wr_data_s = mov_merge(regs_r[bus.Waddr], bus.MovImm);
    end
  end

  // Clear-sweep FSM and its address counter.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r     <= ST_IDLE;
      sweep_cnt_r <= {A{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.ClearReq) begin
            state_r     <= ST_CLEAR;
            sweep_cnt_r <= {A{1'b0}};
          end else begin
            state_r     <= ST_IDLE;
            sweep_cnt_r <= sweep_cnt_r;
          end
        end
        ST_CLEAR: begin
          sweep_cnt_r <= sweep_cnt_r + CNT_ONE;
          if (sweep_cnt_r == CNT_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_CLEAR;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          sweep_cnt_r <= {A{1'b0}};
        end
      endcase
    end
  end

  // Register array: reset, sweep zeroing, then write/move.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < D; i++) begin
        regs_r[i] <= W_ZERO;
      end
    end else if (busy_s) begin
      regs_r[sweep_cnt_r] <= W_ZERO;
    end else if (wr_any_s) begin
      regs_r[bus.Waddr] <= wr_data_s;
    end
  end

  // Read ports, optionally forwarding the value being written this cycle.
  always_comb begin
    rd_a_s = regs_r[bus.RaddrA];
    rd_b_s = regs_r[bus.RaddrB];
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_any_s && (bus.RaddrA == bus.Waddr)) begin
      rd_a_s = wr_data_s;
    end else begin
      rd_a_s = regs_r[bus.RaddrA];
    end
    if (wr_any_s && (bus.RaddrB == bus.Waddr)) begin
      rd_b_s = wr_data_s;
    end else begin
      rd_b_s = regs_r[bus.RaddrB];
    end
`endif
  end

  rf_scoreboard #(.A(A)) u_scoreboard (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr_all   (clr_start_s),
    .set_en    (issue_acc_s),
    .set_addr  (bus.IssueAddr),
    .wr_clr_en (wr_any_s),
    .wr_addr   (bus.Waddr),
    .raddr_a   (bus.RaddrA),
    .raddr_b   (bus.RaddrB),
    .pend_a    (bus.PendA),
    .pend_b    (bus.PendB)
  );

  assign bus.DataOutA  = rd_a_s;
  assign bus.DataOutB  = rd_b_s;
  assign bus.ClearBusy = busy_s;

endmodule
